// File: rtl/rst_seq_gen.sv
// Power-on / fault reset sequencer: synchronises lock and board reset, holds,
// then releases NUM_CH active-low reset domains in ascending order.
module rst_seq_gen #(
  parameter int unsigned NUM_CH      = 2,
  parameter int unsigned HOLD_CYCLES = 1000,
  parameter int unsigned STAGE_GAP   = 16,
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned CNT_W       = 32
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              pll_locked_i,
  input  logic              ext_rst_ni,
  input  logic              sw_rst_req_i,
  output logic [NUM_CH-1:0] rst_no,
  output logic              ready_o,
  output logic [1:0]        state_o,
  output logic [7:0]        fault_cnt_o
);

  localparam int unsigned FCNT_W = 8;
  localparam logic [CNT_W-1:0]  HOLD_LAST = CNT_W'(HOLD_CYCLES - 1);
  localparam logic [CNT_W-1:0]  GAP_LAST  = CNT_W'(STAGE_GAP - 1);
  localparam logic [FCNT_W-1:0] FCNT_MAX  = '1;

  typedef enum logic [1:0] {
    ST_ASSERT  = 2'd0,
    ST_RELEASE = 2'd1,
    ST_RUN     = 2'd2
  } state_e;

  state_e              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [NUM_CH-1:0]   rst_n_q, rst_n_d;
  logic                ready_q, ready_d;
  logic [FCNT_W-1:0]   fault_q, fault_d;
  logic [SYNC_STAGES-1:0] lock_sync_q, ext_sync_q;

  logic              lock_s, ext_s, good;
  logic [NUM_CH-1:0] rel_next;
  logic              rel_all;

  // Input synchronisers; reset value reads as "unlocked, board reset asserted"
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      lock_sync_q <= '0;
      ext_sync_q  <= '0;
    end else begin
      lock_sync_q <= {lock_sync_q[SYNC_STAGES-2:0], pll_locked_i};
      ext_sync_q  <= {ext_sync_q[SYNC_STAGES-2:0], ext_rst_ni};
    end
  end

  assign lock_s = lock_sync_q[SYNC_STAGES-1];
  assign ext_s  = ext_sync_q[SYNC_STAGES-1];
  assign good   = lock_s & ext_s & ~sw_rst_req_i;

  // Releases are thermometer-coded, so the next release shifts in one more '1'
  assign rel_next = NUM_CH'({rst_n_q, 1'b1});
  assign rel_all  = &rel_next;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= ST_ASSERT;
      cnt_q   <= '0;
      rst_n_q <= '0;
      ready_q <= 1'b0;
      fault_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rst_n_q <= rst_n_d;
      ready_q <= ready_d;
      fault_q <= fault_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    rst_n_d = rst_n_q;
    ready_d = ready_q;
    fault_d = fault_q;
    case (state_q)
      ST_ASSERT: begin
        rst_n_d = '0;
        ready_d = 1'b0;
        if (!good) begin
          cnt_d = '0;
        end else if (cnt_q == HOLD_LAST) begin
          cnt_d   = '0;
          rst_n_d = rel_next;
          if (rel_all) begin
            state_d = ST_RUN;
            ready_d = 1'b1;
          end else begin
            state_d = ST_RELEASE;
          end
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      ST_RELEASE, ST_RUN: begin
        if (!good) begin
          // Fault: collapse every domain together and count one re-entry
          state_d = ST_ASSERT;
          cnt_d   = '0;
          rst_n_d = '0;
          ready_d = 1'b0;
          if (fault_q != FCNT_MAX) fault_d = fault_q + FCNT_W'(1);
        end else if (state_q == ST_RUN) begin
          cnt_d = '0;
        end else if (cnt_q == GAP_LAST) begin
          cnt_d   = '0;
          rst_n_d = rel_next;
          if (rel_all) begin
            state_d = ST_RUN;
            ready_d = 1'b1;
          end
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: begin
        state_d = ST_ASSERT;
        cnt_d   = '0;
        rst_n_d = '0;
        ready_d = 1'b0;
      end
    endcase
  end

  assign rst_no      = rst_n_q;
  assign ready_o     = ready_q;
  assign state_o     = state_q;
  assign fault_cnt_o = fault_q;

endmodule

// File: tb/tb_rst_seq_gen.sv
// Directed bench for rst_seq_gen with NUM_CH=3, HOLD_CYCLES=10, STAGE_GAP=4, SYNC_STAGES=2.
module tb_rst_seq_gen;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       pll = 1'b0;
  logic       ext = 1'b0;
  logic       sw  = 1'b0;
  logic [2:0] rst_n;
  logic       ready;
  logic [1:0] state;
  logic [7:0] fcnt;
  logic [13:0] obs;
  logic [13:0] exp_v;
  int errors = 0;
  int checks = 0;

  rst_seq_gen #(
    .NUM_CH(3), .HOLD_CYCLES(10), .STAGE_GAP(4), .SYNC_STAGES(2), .CNT_W(8)
  ) dut (
    .clk_i(clk), .rst_i(rst), .pll_locked_i(pll), .ext_rst_ni(ext),
    .sw_rst_req_i(sw), .rst_no(rst_n), .ready_o(ready), .state_o(state),
    .fault_cnt_o(fcnt)
  );

  always #5 clk = ~clk;

  assign obs = {rst_n, ready, state, fcnt};

  // n = edges since channel 0 was released (negative: still in ASSERT)
  function automatic logic [13:0] expv(int n, int f);
    logic [2:0] r;
    logic       rdy;
    logic [1:0] st;
    r = 3'b000; rdy = 1'b0; st = 2'd0;
    if (n >= 0) begin
      r   = {n >= 8, n >= 4, 1'b1};
      rdy = (n >= 8);
      st  = (n >= 8) ? 2'd2 : 2'd1;
    end
    return {r, rdy, st, 8'(f)};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Leaves the bench 1 time unit after an edge with rst low: next edge is edge 1
  task automatic do_reset(input logic l, input logic e);
    rst = 1'b1; pll = l; ext = e; sw = 1'b0;
    repeat (3) tick();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; pll = 1'b1; ext = 1'b1; sw = 1'b0;
    tick();
    checks++;
    if (obs !== 14'h0) begin
      errors++;
      $display("FAIL reset got=%h exp=%h", obs, 14'h0);
    end
  endtask

  task automatic test_powerup();
    do_reset(1'b1, 1'b1);
    for (int e = 1; e <= 22; e++) begin
      tick();
      exp_v = expv(e - 12, 0);
      checks++;
      if (obs !== exp_v) begin
        errors++;
        $display("FAIL powerup edge=%0d got=%h exp=%h", e, obs, exp_v);
      end
    end
  endtask

  task automatic test_lock_glitch();
    do_reset(1'b1, 1'b1);
    for (int e = 1; e <= 30; e++) begin
      tick();
      exp_v = expv(e - 20, 0);
      checks++;
      if (obs !== exp_v) begin
        errors++;
        $display("FAIL lock_glitch edge=%0d got=%h exp=%h", e, obs, exp_v);
      end
      if (e == 7) pll = 1'b0;
      if (e == 8) pll = 1'b1;
    end
  endtask

  task automatic test_ext_fault();
    do_reset(1'b1, 1'b1);
    for (int e = 1; e <= 48; e++) begin
      tick();
      exp_v = (e < 25) ? expv(e - 12, 0) : expv(e - 37, 1);
      checks++;
      if (obs !== exp_v) begin
        errors++;
        $display("FAIL ext_fault edge=%0d got=%h exp=%h", e, obs, exp_v);
      end
      if (e == 22) ext = 1'b0;
      if (e == 25) ext = 1'b1;
    end
  endtask

  task automatic test_sw_release();
    do_reset(1'b1, 1'b1);
    for (int e = 1; e <= 26; e++) begin
      tick();
      exp_v = (e < 14) ? expv(e - 12, 0) : expv(e - 24, 1);
      checks++;
      if (obs !== exp_v) begin
        errors++;
        $display("FAIL sw_release edge=%0d got=%h exp=%h", e, obs, exp_v);
      end
      if (e == 13) sw = 1'b1;
      if (e == 14) sw = 1'b0;
    end
  endtask

  // Continues from test_sw_release: mid-RELEASE with fault count 1
  task automatic test_async_reset();
    #2;
    rst = 1'b1;
    #1;
    checks++;
    if (obs !== 14'h0) begin
      errors++;
      $display("FAIL async_reset got=%h exp=%h", obs, 14'h0);
    end
    tick();
    tick();
    rst = 1'b0;
    for (int e = 1; e <= 22; e++) begin
      tick();
      exp_v = expv(e - 12, 0);
      checks++;
      if (obs !== exp_v) begin
        errors++;
        $display("FAIL async_replay edge=%0d got=%h exp=%h", e, obs, exp_v);
      end
    end
  endtask

  task automatic test_simultaneous();
    do_reset(1'b1, 1'b1);
    for (int e = 1; e <= 30; e++) begin
      tick();
      exp_v = (e < 25) ? expv(e - 12, 0) : expv(-1, 1);
      checks++;
      if (obs !== exp_v) begin
        errors++;
        $display("FAIL simultaneous edge=%0d got=%h exp=%h", e, obs, exp_v);
      end
      if (e == 22) begin pll = 1'b0; ext = 1'b0; end
      if (e == 24) sw = 1'b1;
      if (e == 25) sw = 1'b0;
      if (e == 28) begin pll = 1'b1; ext = 1'b1; end
    end
  endtask

  task automatic test_saturate();
    int fe;
    int w;
    logic [9:0] got;
    logic [9:0] want;
    fe = 0;
    do_reset(1'b1, 1'b1);
    for (int i = 1; i <= 300; i++) begin
      w = 0;
      while (state !== 2'd2 && w < 40) begin
        tick();
        w++;
      end
      if (w >= 40) begin
        checks++;
        errors++;
        $display("FAIL saturate_timeout iter=%0d state=%0d exp=2", i, state);
        break;
      end
      sw = 1'b1;
      tick();
      sw = 1'b0;
      fe = (fe < 255) ? fe + 1 : 255;
      got  = {state, fcnt};
      want = {2'd0, 8'(fe)};
      checks++;
      if (got !== want) begin
        errors++;
        $display("FAIL saturate iter=%0d got=%h exp=%h", i, got, want);
      end
    end
    repeat (5) tick();
    checks++;
    if (fcnt !== 8'd255) begin
      errors++;
      $display("FAIL saturate_hold got=%0d exp=255", fcnt);
    end
  endtask

  initial begin
    test_reset();
    test_powerup();
    test_lock_glitch();
    test_ext_fault();
    test_sw_release();
    test_async_reset();
    test_simultaneous();
    test_saturate();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
